// File: rtl/mbledhesi_serial.sv
// Slice-serial adder/subtractor: SLICE bits per clock, carry held between slices.
// Optional result saturation on signed overflow when MBLEDHESI_SAT_EN is defined.
module mbledhesi_serial #(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow,
    output logic             zero
);

    localparam int N  = WIDTH / SLICE;
    localparam int KW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state, state_nxt;
    logic [KW-1:0]    k;
    logic             carry;
    logic [WIDTH-1:0] opa, opb, acc;

    logic [SLICE-1:0] slice_sum;
    logic [SLICE:0]   slice_c;
    logic [WIDTH-1:0] acc_nxt;
    logic             last_slice;
    logic             msb_cin;
    logic             ovf_nxt;
    logic [WIDTH-1:0] final_res;

    assign last_slice = (k == KW'(N - 1));
    assign busy       = (state == RUN);

    // Ripple of full-adder cells over the current low slice of the operand shifters.
    always_comb begin
        slice_c    = '0;
        slice_sum  = '0;
        slice_c[0] = carry;
        for (int i = 0; i < SLICE; i++) begin
            slice_sum[i]  = opa[i] ^ opb[i] ^ slice_c[i];
            slice_c[i+1]  = (opa[i] & opb[i]) | (opa[i] & slice_c[i]) | (opb[i] & slice_c[i]);
        end
        msb_cin = slice_c[SLICE-1];
        ovf_nxt = msb_cin ^ slice_c[SLICE];
    end

    generate
        if (N == 1) begin : g_single
            assign acc_nxt = slice_sum;
        end else begin : g_multi
            assign acc_nxt = {slice_sum, acc[WIDTH-1:SLICE]};
        end
    endgenerate

`ifdef MBLEDHESI_SAT_EN
    // The wrapped MSB is the inverse of the true sign when overflow occurs.
    always_comb begin
        final_res = acc_nxt;
        if (ovf_nxt)
            final_res = acc_nxt[WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}}
                                         : {1'b1, {(WIDTH-1){1'b0}}};
    end
`else
    assign final_res = acc_nxt;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = RUN;
            RUN:  if (last_slice) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k        <= '0;
            carry    <= 1'b0;
            opa      <= '0;
            opb      <= '0;
            acc      <= '0;
            done     <= 1'b0;
            result   <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
            zero     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                if (start) begin
                    opa   <= a;
                    opb   <= sub ? ~b : b;
                    carry <= sub;
                    k     <= '0;
                end
            end else begin
                opa   <= opa >> SLICE;
                opb   <= opb >> SLICE;
                acc   <= acc_nxt;
                carry <= slice_c[SLICE];
                k     <= k + 1'b1;
                if (last_slice) begin
                    done     <= 1'b1;
                    result   <= final_res;
                    cout     <= slice_c[SLICE];
                    overflow <= ovf_nxt;
                    zero     <= (final_res == '0);
                end
            end
        end
    end

endmodule

// File: tb/tb_mbledhesi_serial.sv
// Directed self-checking bench for mbledhesi_serial (WIDTH=16, SLICE=4).
module tb_mbledhesi_serial;

    localparam int WIDTH = 16;
    localparam int SLICE = 4;
    localparam int N     = WIDTH / SLICE;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             sub = 1'b0;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             busy, done, cout, overflow, zero;
    logic [WIDTH-1:0] result;

    int checks = 0;
    int errors = 0;
    logic [WIDTH-1:0] held_result = '0;

    mbledhesi_serial #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b),
        .busy(busy), .done(done), .result(result), .cout(cout),
        .overflow(overflow), .zero(zero)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drives a start request before an edge and releases it after that edge (E0).
    task automatic applyStimulus(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb, input logic vsub);
        @(negedge clk);
        a = va; b = vb; sub = vsub; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = $urandom; b = $urandom; sub = $urandom_range(0, 1);
    endtask

    task automatic runOp(input string tag, input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                         input logic vsub, input logic [WIDTH-1:0] er, input logic ec,
                         input logic eo, input logic ez);
        applyStimulus(va, vb, vsub);
        checkOutput({tag, " busy@E0"}, busy, 1);
        checkOutput({tag, " done@E0"}, done, 0);
        for (int i = 1; i < N; i++) begin
            @(negedge clk);
            checkOutput({tag, " busy run"}, busy, 1);
            checkOutput({tag, " held result"}, result, held_result);
        end
        @(negedge clk);
        checkOutput({tag, " done"}, done, 1);
        checkOutput({tag, " busy end"}, busy, 0);
        checkOutput({tag, " result"}, result, er);
        checkOutput({tag, " cout"}, cout, ec);
        checkOutput({tag, " overflow"}, overflow, eo);
        checkOutput({tag, " zero"}, zero, ez);
        held_result = er;
        @(negedge clk);
        checkOutput({tag, " done pulse"}, done, 0);
        checkOutput({tag, " result hold"}, result, er);
    endtask

    initial begin
        // Reset with random inputs
        a = $urandom; b = $urandom; sub = 1'b1; start = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("rst busy", busy, 0);
        checkOutput("rst done", done, 0);
        checkOutput("rst result", result, 0);
        checkOutput("rst flags", {cout, overflow, zero}, 0);
        start = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("idle busy", busy, 0);
            checkOutput("idle outs", {done, result, cout, overflow, zero}, 0);
        end

        runOp("add1", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0);
        runOp("addwrap", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        runOp("sub5m7", 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
`ifdef MBLEDHESI_SAT_EN
        runOp("addovf", 16'h7FFF, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0);
        runOp("subovf", 16'h8000, 16'h0001, 1'b1, 16'h8000, 1'b1, 1'b1, 1'b0);
`else
        runOp("addovf", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
        runOp("subovf", 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);
`endif

        // Start during RUN is ignored; held across done it begins the next op
        applyStimulus(16'h1000, 16'h2000, 1'b0);
        a = 16'h0001; b = 16'h0001; sub = 1'b0; start = 1'b1;
        for (int i = 1; i < N; i++) begin
            @(negedge clk);
            checkOutput("ign busy", busy, 1);
        end
        @(negedge clk);
        checkOutput("ign done", done, 1);
        checkOutput("ign result", result, 16'h3000);
        @(negedge clk);
        start = 1'b0;
        checkOutput("b2b busy", busy, 1);
        checkOutput("b2b done low", done, 0);
        for (int i = 1; i < N; i++) @(negedge clk);
        @(negedge clk);
        checkOutput("b2b done", done, 1);
        checkOutput("b2b result", result, 16'h0002);
        held_result = 16'h0002;
        @(negedge clk);

        // Reset mid-operation after E2
        applyStimulus(16'h1111, 16'h1111, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("abort busy", busy, 0);
        checkOutput("abort result", result, 0);
        checkOutput("abort done", done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        held_result = '0;
        for (int i = 0; i < N + 1; i++) begin
            @(negedge clk);
            checkOutput("abort no done", {done, busy}, 0);
        end
        runOp("after", 16'h0101, 16'h0202, 1'b0, 16'h0303, 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
